// File: rtl/exp_filter_mc_pkg.sv
// rtl/exp_filter_mc_pkg.sv - shared sizing helpers for the multi-channel exponential filter
package exp_filter_mc_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel tag width; a single-channel build still carries a 1-bit tag
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/exp_filter_mac.sv
// rtl/exp_filter_mac.sv - combinational state update: state + floor((x<<<GUARD - state) * alpha)
module exp_filter_mac #(
    parameter int WIDTH       = 16,
    parameter int ALPHA_WIDTH = 32,
    parameter int GUARD       = 16
) (
    input  logic signed [WIDTH+GUARD-1:0] state,
    input  logic signed [WIDTH-1:0]       x,
    input  logic        [ALPHA_WIDTH-1:0] alpha,
    output logic signed [WIDTH+GUARD-1:0] new_state
);
    localparam int SW = WIDTH + GUARD;
    localparam int DW = SW + 1;
    localparam int PW = DW + ALPHA_WIDTH + 1;

    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] state_ext;
    logic signed [DW-1:0] diff;
    logic signed [PW-1:0] diff_w;
    logic signed [PW-1:0] alpha_w;
    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] adj;
    logic signed [DW-1:0] sum;
    logic                 unused_bits;

    // Slicing prod above ALPHA_WIDTH is the floor shift; |adj| <= |diff| so DW bits hold it
    always_comb begin
        x_sh        = {x[WIDTH-1], x, {GUARD{1'b0}}};
        state_ext   = {state[SW-1], state};
        diff        = x_sh - state_ext;
        diff_w      = {{(PW-DW){diff[DW-1]}}, diff};
        alpha_w     = {{(PW-ALPHA_WIDTH){1'b0}}, alpha};
        prod        = diff_w * alpha_w;
        adj         = prod[ALPHA_WIDTH+DW-1:ALPHA_WIDTH];
        sum         = state_ext + adj;
        new_state   = sum[SW-1:0];
        unused_bits = ^{prod[PW-1:ALPHA_WIDTH+DW], prod[ALPHA_WIDTH-1:0], sum[DW-1]};
    end

endmodule

// File: rtl/exp_filter_mc.sv
// rtl/exp_filter_mc.sv - time-multiplexed N-channel exponential filter; EXP_FILTER_PRIME_EN enables first-sample priming
module exp_filter_mc
    import exp_filter_mc_pkg::*;
#(
    parameter int                     WIDTH       = 16,
    parameter int                     ALPHA_WIDTH = 32,
    parameter int                     GUARD       = 16,
    parameter int                     N_CH        = 4,
    parameter logic [ALPHA_WIDTH-1:0] ALPHA_RST   = ALPHA_WIDTH'(2147484),
    localparam int                    CW          = ch_width(N_CH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic        [CW-1:0]          in_ch,
    input  logic signed [WIDTH-1:0]       in_data,
    input  logic                          alpha_we,
    input  logic        [CW-1:0]          alpha_ch,
    input  logic        [ALPHA_WIDTH-1:0] alpha_data,
    output logic                          out_valid,
    output logic        [CW-1:0]          out_ch,
    output logic signed [WIDTH-1:0]       out_data
);
    localparam int            SW     = WIDTH + GUARD;
    localparam logic [CW:0]   N_CH_L = (CW+1)'(N_CH);

    logic signed [SW-1:0]          state_q [N_CH];
    logic signed [SW-1:0]          state_d [N_CH];
    logic        [ALPHA_WIDTH-1:0] alpha_q [N_CH];
    logic        [ALPHA_WIDTH-1:0] alpha_d [N_CH];

    logic                          s1_valid_q, s1_valid_d;
    logic        [CW-1:0]          s1_ch_q, s1_ch_d;
    logic signed [WIDTH-1:0]       s1_x_q, s1_x_d;
    logic signed [SW-1:0]          s1_state_q, s1_state_d;
    logic        [ALPHA_WIDTH-1:0] s1_alpha_q, s1_alpha_d;

    logic                          out_valid_q, out_valid_d;
    logic        [CW-1:0]          out_ch_q, out_ch_d;
    logic signed [WIDTH-1:0]       out_data_q, out_data_d;

    logic                          in_ok;
    logic                          fwd;
    logic        [CW-1:0]          rd_ch;
    logic signed [SW-1:0]          mac_state;
    logic signed [SW-1:0]          s2_state;

`ifdef EXP_FILTER_PRIME_EN
    logic                          primed_q [N_CH];
    logic                          primed_d [N_CH];
    logic                          s1_primed_q, s1_primed_d;
`endif

    exp_filter_mac #(
        .WIDTH       (WIDTH),
        .ALPHA_WIDTH (ALPHA_WIDTH),
        .GUARD       (GUARD)
    ) u_mac (
        .state     (s1_state_q),
        .x         (s1_x_q),
        .alpha     (s1_alpha_q),
        .new_state (mac_state)
    );

    // Accept filter and forwarding detect: a same-channel sample in S2 supplies the state S1 reads
    always_comb begin
        in_ok = in_valid && ({1'b0, in_ch} < N_CH_L);
        rd_ch = in_ok ? in_ch : '0;
        fwd   = s1_valid_q && (s1_ch_q == in_ch);
`ifdef EXP_FILTER_PRIME_EN
        s2_state = s1_primed_q ? mac_state : {s1_x_q, {GUARD{1'b0}}};
`else
        s2_state = mac_state;
`endif
    end

    // Register-file write-back of the S2 result and runtime alpha writes
    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        if (s1_valid_q) begin
            state_d[s1_ch_q] = s2_state;
        end
        if (alpha_we && ({1'b0, alpha_ch} < N_CH_L)) begin
            alpha_d[alpha_ch] = alpha_data;
        end
    end

`ifdef EXP_FILTER_PRIME_EN
    // Primed flags follow the same write-back and forwarding path as the state
    always_comb begin
        primed_d = primed_q;
        if (s1_valid_q) begin
            primed_d[s1_ch_q] = 1'b1;
        end
        s1_primed_d = fwd ? 1'b1 : primed_q[rd_ch];
    end
`endif

    // S1 capture and S2 output register next values
    always_comb begin
        s1_valid_d  = in_ok;
        s1_ch_d     = rd_ch;
        s1_x_d      = in_data;
        s1_state_d  = fwd ? s2_state : state_q[rd_ch];
        s1_alpha_d  = alpha_q[rd_ch];
        out_valid_d = s1_valid_q;
        out_ch_d    = s1_valid_q ? s1_ch_q : out_ch_q;
        out_data_d  = s1_valid_q ? s2_state[SW-1:GUARD] : out_data_q;
    end

    // All storage with synchronous active-low reset; in-flight samples are dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= '0;
                alpha_q[i] <= ALPHA_RST;
`ifdef EXP_FILTER_PRIME_EN
                primed_q[i] <= 1'b0;
`endif
            end
`ifdef EXP_FILTER_PRIME_EN
            s1_primed_q <= 1'b0;
`endif
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_x_q      <= '0;
            s1_state_q  <= '0;
            s1_alpha_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            alpha_q     <= alpha_d;
`ifdef EXP_FILTER_PRIME_EN
            primed_q    <= primed_d;
            s1_primed_q <= s1_primed_d;
`endif
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_x_q      <= s1_x_d;
            s1_state_q  <= s1_state_d;
            s1_alpha_q  <= s1_alpha_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_exp_filter_mc.sv
// tb/tb_exp_filter_mc.sv - self-checking bench for exp_filter_mc (N_CH=4, plus an N_CH=3 instance)
module tb_exp_filter_mc;

    localparam int W  = 16;
    localparam int AW = 32;
    localparam int G  = 16;
    localparam int N  = 4;
    localparam logic [31:0] HALF = 32'h8000_0000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic        [1:0]    in_ch;
    logic signed [W-1:0]  in_data;
    logic                 alpha_we;
    logic        [1:0]    alpha_ch;
    logic        [AW-1:0] alpha_data;
    logic                 out_valid;
    logic        [1:0]    out_ch;
    logic signed [W-1:0]  out_data;

    logic                 in_valid3;
    logic        [1:0]    in_ch3;
    logic signed [W-1:0]  in_data3;
    logic                 alpha_we3;
    logic        [1:0]    alpha_ch3;
    logic        [AW-1:0] alpha_data3;
    logic                 out_valid3;
    logic        [1:0]    out_ch3;
    logic signed [W-1:0]  out_data3;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    typedef struct {
        int due;
        int ch;
        int data;
    } exp_t;

    exp_t                 eq[$];
    int                   log_ch[$];
    int                   log_data[$];
    logic signed [127:0]  m_state [N];
    logic        [31:0]   m_alpha [N];
    bit                   m_primed [N];
    logic signed [127:0]  m_xs, m_d, m_a, m_p;
    exp_t                 e;
    bit                   exp_valid;

    always #5 clk = ~clk;

    exp_filter_mc #(.WIDTH(W), .ALPHA_WIDTH(AW), .GUARD(G), .N_CH(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .alpha_we   (alpha_we),
        .alpha_ch   (alpha_ch),
        .alpha_data (alpha_data),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data)
    );

    exp_filter_mc #(.WIDTH(W), .ALPHA_WIDTH(AW), .GUARD(G), .N_CH(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid3),
        .in_ch      (in_ch3),
        .in_data    (in_data3),
        .alpha_we   (alpha_we3),
        .alpha_ch   (alpha_ch3),
        .alpha_data (alpha_data3),
        .out_valid  (out_valid3),
        .out_ch     (out_ch3),
        .out_data   (out_data3)
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic chk_log(input int idx, input int ch, input int data);
        if (idx >= log_data.size()) begin
            checks++;
            errors++;
            $display("FAIL log[%0d] missing: got %0d entries want ch %0d data %0d", idx, log_data.size(), ch, data);
        end else begin
            chk($sformatf("log[%0d].ch", idx), log_ch[idx], ch);
            chk($sformatf("log[%0d].data", idx), log_data[idx], data);
        end
    endtask

    // Check outputs from the previous edge, then feed the model the inputs the next edge will see
    always @(negedge clk) begin
        ncyc++;
        exp_valid = (eq.size() > 0) && (eq[0].due == ncyc);
        chk("out_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
            e = eq.pop_front();
            chk("out_ch", int'(out_ch), e.ch);
            chk("out_data", int'(out_data), e.data);
        end
        if (out_valid === 1'b1) begin
            log_ch.push_back(int'(out_ch));
            log_data.push_back(int'(out_data));
        end
        if (reset !== 1'b1) begin
            eq.delete();
            for (int i = 0; i < N; i++) begin
                m_state[i]  = '0;
                m_alpha[i]  = 32'd2147484;
                m_primed[i] = 1'b0;
            end
        end else begin
            if (in_valid === 1'b1 && int'(in_ch) < N) begin
                m_xs = 128'(in_data);
                m_xs = m_xs <<< G;
`ifdef EXP_FILTER_PRIME_EN
                if (!m_primed[in_ch]) begin
                    m_state[in_ch] = m_xs;
                end else begin
`else
                begin
`endif
                    m_d = m_xs - m_state[in_ch];
                    m_a = {96'd0, m_alpha[in_ch]};
                    m_p = m_d * m_a;
                    m_state[in_ch] = m_state[in_ch] + (m_p >>> AW);
                end
                m_primed[in_ch] = 1'b1;
                eq.push_back('{due: ncyc + 2, ch: int'(in_ch), data: int'(m_state[in_ch] >>> G)});
            end
            if (alpha_we === 1'b1 && int'(alpha_ch) < N) begin
                m_alpha[alpha_ch] = alpha_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int x);
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_data  = W'(x);
        step();
        in_valid = 1'b0;
    endtask

    task automatic set_alpha(input int ch, input logic [31:0] a);
        alpha_we   = 1'b1;
        alpha_ch   = 2'(ch);
        alpha_data = a;
        step();
        alpha_we   = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        log_ch.delete();
        log_data.delete();
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_ch       = '0;
        in_data     = '0;
        alpha_we    = 1'b0;
        alpha_ch    = '0;
        alpha_data  = '0;
        in_valid3   = 1'b0;
        in_ch3      = '0;
        in_data3    = '0;
        alpha_we3   = 1'b0;
        alpha_ch3   = '0;
        alpha_data3 = '0;
        wait_cycles(3);
        @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_ch", int'(out_ch), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_valid3", int'(out_valid3), 0);
        step();
        reset = 1'b1;
        step();

        // ch0 step, samples spaced three cycles apart
        set_alpha(0, HALF);
        clear_log();
        for (int i = 0; i < 4; i++) begin
            send(0, 1000);
            wait_cycles(2);
        end
        wait_cycles(3);
`ifndef EXP_FILTER_PRIME_EN
        chk_log(0, 0, 500);
        chk_log(1, 0, 750);
        chk_log(2, 0, 875);
        chk_log(3, 0, 937);
`endif

        // ch1 negative step back-to-back exercises forwarding
        set_alpha(1, HALF);
        clear_log();
        for (int i = 0; i < 4; i++) send(1, -1000);
        wait_cycles(4);
`ifndef EXP_FILTER_PRIME_EN
        chk_log(0, 1, -500);
        chk_log(1, 1, -750);
        chk_log(2, 1, -875);
        chk_log(3, 1, -938);
`endif

        // interleaved channels with different alphas stay independent
        pulse_reset();
        set_alpha(0, HALF);
        set_alpha(2, 32'd0);
        clear_log();
        send(0, 1000);
        send(2, 1000);
        send(0, 1000);
        send(2, 1000);
        wait_cycles(4);
`ifndef EXP_FILTER_PRIME_EN
        chk_log(0, 0, 500);
        chk_log(1, 2, 0);
        chk_log(2, 0, 750);
        chk_log(3, 2, 0);
`endif

        // alpha write on the same edge as a sample: that sample keeps the old alpha
        pulse_reset();
        clear_log();
        alpha_we   = 1'b1;
        alpha_ch   = 2'd3;
        alpha_data = HALF;
        send(3, 1000);
        alpha_we   = 1'b0;
        send(3, 1000);
        wait_cycles(4);
`ifndef EXP_FILTER_PRIME_EN
        chk_log(0, 3, 0);
        chk_log(1, 3, 500);
`endif

        // reset asserted with a sample in flight
        set_alpha(0, HALF);
        send(0, 1000);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("mid-reset out_valid", int'(out_valid), 0);
        step();
        reset = 1'b1;
        step();
        set_alpha(0, HALF);
        clear_log();
        send(0, 1000);
        wait_cycles(4);
`ifndef EXP_FILTER_PRIME_EN
        chk_log(0, 0, 500);
`endif

        // N_CH=3 instance: out-of-range channel is dropped, in-range one passes
        in_valid3 = 1'b1;
        in_ch3    = 2'd3;
        in_data3  = 16'sd1000;
        step();
        in_valid3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("n3 drop out_valid3", int'(out_valid3), 0);
        end
        step();
        in_valid3 = 1'b1;
        in_ch3    = 2'd2;
        in_data3  = 16'sd1000;
        step();
        in_valid3 = 1'b0;
        @(negedge clk);
        chk("n3 early out_valid3", int'(out_valid3), 0);
        @(negedge clk);
        chk("n3 out_valid3", int'(out_valid3), 1);
        chk("n3 out_ch3", int'(out_ch3), 2);
        chk("n3 out_data3", int'(out_data3), 0);
        step();

`ifdef EXP_FILTER_PRIME_EN
        // priming: first sample of a channel loads the state directly
        pulse_reset();
        set_alpha(0, HALF);
        clear_log();
        send(0, 1000);
        send(0, 0);
        wait_cycles(4);
        chk_log(0, 0, 1000);
        chk_log(1, 0, 500);
        pulse_reset();
        clear_log();
        send(0, 1000);
        wait_cycles(4);
        chk_log(0, 0, 1000);
`endif

        wait_cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
